// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: first-word-fall-through ADC sample FIFO with output code transform and drop accounting
module adc_sample_fifo #(
  parameter int DATA_W     = 14,
  parameter int DEPTH_LOG2 = 4,
  parameter bit INVERT     = 1,
  parameter bit OB2TC      = 0
) (
  input  logic                  sys_CLK,
  input  logic                  sys_RST,
  input  logic [DATA_W-1:0]     Ain,
  input  logic                  Ain_valid,
  output logic [DATA_W-1:0]     Aout,
  output logic                  Aout_valid,
  input  logic                  Aout_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  input  logic                  ovf_clr
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] full_lvl = (DEPTH_LOG2 + 1)'(DEPTH);
  // inversion and MSB flip collapse into one constant XOR mask
  localparam logic [DATA_W-1:0] xmask = {DATA_W{INVERT}} ^ {OB2TC, {(DATA_W - 1){1'b0}}};
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic push, pop, drop;
  assign full       = level == full_lvl;
  assign empty      = level == '0;
  assign Aout_valid = !empty;
  assign pop        = Aout_valid & Aout_ready;
  assign push       = Ain_valid & (!full | pop);
  assign drop       = Ain_valid & full & !pop;
  assign Aout       = Aout_valid ? mem[rd_ptr] ^ xmask : '0;
  always_ff @(posedge sys_CLK)
    if (!sys_RST && push) mem[wr_ptr] <= Ain;
  always_ff @(posedge sys_CLK) begin
    if (sys_RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
      // a drop in the clearing cycle is recorded as the first drop after the clear
      if (ovf_clr) begin
        overflow <= drop;
        drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt == 16'hFFFF ? drop_cnt : drop_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb_adc_sample_fifo: directed checks of the ADC sample FIFO, default and OB2TC-only transforms
module tb_adc_sample_fifo;
  logic sys_CLK = 1'b0;
  logic sys_RST = 1'b1;
  logic [13:0] Ain = '0, Ain2 = '0;
  logic Ain_valid = 1'b0, Ain_valid2 = 1'b0;
  logic Aout_ready = 1'b0, Aout_ready2 = 1'b0;
  logic ovf_clr = 1'b0, ovf_clr2 = 1'b0;
  logic [13:0] Aout, Aout2;
  logic Aout_valid, Aout_valid2, full, full2, empty, empty2, overflow, overflow2;
  logic [4:0] level, level2;
  logic [15:0] drop_cnt, drop_cnt2;
  logic [13:0] e;
  int tests = 0, fails = 0;

  always #5 sys_CLK = ~sys_CLK;

  adc_sample_fifo dut (
    .sys_CLK(sys_CLK), .sys_RST(sys_RST), .Ain(Ain), .Ain_valid(Ain_valid),
    .Aout(Aout), .Aout_valid(Aout_valid), .Aout_ready(Aout_ready), .level(level),
    .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  adc_sample_fifo #(.INVERT(1'b0), .OB2TC(1'b1)) dut2 (
    .sys_CLK(sys_CLK), .sys_RST(sys_RST), .Ain(Ain2), .Ain_valid(Ain_valid2),
    .Aout(Aout2), .Aout_valid(Aout_valid2), .Aout_ready(Aout_ready2), .level(level2),
    .full(full2), .empty(empty2), .overflow(overflow2), .drop_cnt(drop_cnt2), .ovf_clr(ovf_clr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_CLK);
    #1;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(Aout_valid), 32'd0);
    chk("rst_aout", 32'(Aout), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_cnt), 32'd0);
    sys_RST = 1'b0;
    Ain = 14'h0005;
    Ain_valid = 1'b1;
    tick;
    Ain_valid = 1'b0;
    chk("t1_valid", 32'(Aout_valid), 32'd1);
    chk("t1_aout", 32'(Aout), 32'h3FFA);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    Aout_ready = 1'b1;
    tick;
    Aout_ready = 1'b0;
    chk("t1_drained", 32'(level), 32'd0);
    for (int i = 0; i < 18; i++) begin
      Ain = 14'(i);
      Ain_valid = 1'b1;
      tick;
      if (i == 15) chk("t2_full16", 32'(full), 32'd1);
    end
    Ain_valid = 1'b0;
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drops", 32'(drop_cnt), 32'd2);
    tick;
    chk("t2_hold", 32'(Aout), 32'h3FFF);
    for (int k = 0; k < 5; k++) begin
      Ain = 14'(100 + k);
      Ain_valid = 1'b1;
      Aout_ready = 1'b1;
      e = ~14'(k);
      chk("t3_head", 32'(Aout), 32'(e));
      tick;
    end
    Ain_valid = 1'b0;
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_drops", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      e = i < 11 ? ~14'(5 + i) : ~14'(89 + i);
      chk("t2_drain", 32'(Aout), 32'(e));
      tick;
    end
    Aout_ready = 1'b0;
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_nvalid", 32'(Aout_valid), 32'd0);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_cnt), 32'd0);
    Aout_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      Ain = 14'(k * 397 + 3);
      Ain_valid = 1'b1;
      tick;
      e = ~14'(k * 397 + 3);
      chk("t4_aout", 32'(Aout), 32'(e));
      chk("t4_level", 32'(level), 32'd1);
    end
    Ain_valid = 1'b0;
    tick;
    Aout_ready = 1'b0;
    chk("t4_empty", 32'(level), 32'd0);
    chk("t4_drops", 32'(drop_cnt), 32'd0);
    Ain2 = 14'h2000;
    Ain_valid2 = 1'b1;
    tick;
    chk("t5_2000", 32'(Aout2), 32'h0000);
    Aout_ready2 = 1'b1;
    Ain2 = 14'h0000;
    tick;
    chk("t5_0000", 32'(Aout2), 32'h2000);
    Ain2 = 14'h3FFF;
    tick;
    chk("t5_3fff", 32'(Aout2), 32'h1FFF);
    chk("t5_level", 32'(level2), 32'd1);
    Ain_valid2 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      Ain = 14'(i);
      Ain_valid = 1'b1;
      tick;
    end
    chk("t6_drop1", 32'(drop_cnt), 32'd1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    Ain_valid = 1'b0;
    chk("t6_clrdrop_ovf", 32'(overflow), 32'd1);
    chk("t6_clrdrop_cnt", 32'(drop_cnt), 32'd1);
    Aout_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick;
    Aout_ready = 1'b0;
    chk("t6_level7", 32'(level), 32'd7);
    sys_RST = 1'b1;
    Ain_valid = 1'b1;
    tick;
    sys_RST = 1'b0;
    Ain_valid = 1'b0;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_valid", 32'(Aout_valid), 32'd0);
    chk("t6_aout", 32'(Aout), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_drops", 32'(drop_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
